// File: rtl/xgmii_rx_stats_pkg.sv
// Shared XGMII control characters, FSM encoding, lane-decode result type
// and saturating adders for the RX statistics engine.
package xgmii_rx_stats_pkg;
   localparam int         NUM_LANES   = 8;
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_ERR   = 8'hFE;
   localparam logic [7:0] XGMII_IDLE  = 8'h07;

   typedef enum logic {IDLE = 1'b0, DATA = 1'b1} rx_state_e;

   typedef struct packed {
      logic       start_l0;
      logic       start_l4;
      logic       term_vld;
      logic [2:0] term_lane;
      logic       err;
      logic       other_ctl;
   } lane_dec_t;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction
endpackage

// File: rtl/xgmii_rx_stats_lane_decode.sv
// Registered per-lane classification of one 64-bit XGMII word into the
// start / terminate / error / stray-control summary the frame FSM consumes.
module xgmii_lane_decode
   import xgmii_rx_stats_pkg::*;
(
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic [NUM_LANES*8-1:0] rxd,
   input  logic [NUM_LANES-1:0]   rxc,
   output lane_dec_t              dec
);
   logic [NUM_LANES-1:0] is_start, is_term, is_err;
   lane_dec_t            dec_d;
   logic                 seen_term;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      assign is_start[k] = rxc[k] & (rxd[8*k +: 8] == XGMII_START);
      assign is_term[k]  = rxc[k] & (rxd[8*k +: 8] == XGMII_TERM);
      assign is_err[k]   = rxc[k] & (rxd[8*k +: 8] == XGMII_ERR);
   end

   always_comb begin
      dec_d          = '0;
      seen_term      = 1'b0;
      dec_d.start_l0 = is_start[0];
      dec_d.start_l4 = is_start[4];
      dec_d.term_vld = |is_term;
      dec_d.err      = |is_err;
      for (int k = NUM_LANES - 1; k >= 0; k--)
         if (is_term[k]) dec_d.term_lane = 3'(k);
      // Control chars after the terminate (idles, a lane-4 restart) are legal.
      for (int k = 0; k < NUM_LANES; k++) begin
         if (is_term[k]) seen_term = 1'b1;
         if (!seen_term && rxc[k] && !is_err[k] && !(is_start[k] && (k == 0 || k == 4)))
            dec_d.other_ctl = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) dec <= '0;
      else         dec <= dec_d;
   end
endmodule

// File: rtl/xgmii_rx_stats.sv
// Per-port XGMII RX statistics: frame delimiting and length check, error
// total, and per-period good-frame / good-byte snapshots.
module xgmii_rx_stats
   import xgmii_rx_stats_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = 156_250_000,
   parameter int unsigned MIN_LEN     = 64,
   parameter int unsigned MAX_LEN     = 1518
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [63:0] xgmii_rxd,
   input  logic [7:0]  xgmii_rxc,
   output logic        frame_done,
   output logic [15:0] frame_len,
   output logic        frame_bad,
   output logic [31:0] rx_pps,
   output logic [31:0] rx_throughput,
   output logic [31:0] rx_err_total,
   output logic        period_tick
);
   lane_dec_t   dec;
   rx_state_e   state;
   logic [15:0] acc, close_acc, close_len;
   logic        bad_seen, close, close_err, giant, runt;
   logic [31:0] tick_cnt, pps_acc, byte_acc, pps_next, byte_next;
   logic        tick, good;

   xgmii_lane_decode u_dec (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .rxd     (xgmii_rxd),
      .rxc     (xgmii_rxc),
      .dec     (dec)
   );

   always_comb begin
      close     = 1'b0;
      close_err = bad_seen;
      close_acc = acc;
      if (state == DATA) begin
         if (dec.start_l0) begin
            close     = 1'b1;
            close_err = 1'b1;
         end else if (dec.term_vld) begin
            close     = 1'b1;
            close_acc = sat_add16(acc, {13'd0, dec.term_lane});
            close_err = bad_seen | dec.err | dec.other_ctl;
         end else if (dec.start_l4) begin
            close     = 1'b1;
            close_err = 1'b1;
            close_acc = sat_add16(acc, 16'd4);
         end
      end
      // acc counts the 8 preamble/SFD bytes, the start char being byte 0.
      close_len = (close_acc < 16'd8) ? 16'd0 : close_acc - 16'd8;
      giant     = close_len > 16'(MAX_LEN);
      runt      = close_len < 16'(MIN_LEN);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= IDLE;
         acc        <= '0;
         bad_seen   <= 1'b0;
         frame_done <= 1'b0;
         frame_len  <= '0;
         frame_bad  <= 1'b0;
      end else begin
         frame_done <= close;
         if (close) begin
            frame_len <= giant ? 16'(MAX_LEN + 1) : close_len;
            frame_bad <= close_err | runt | giant;
         end
         case (state)
            IDLE: begin
               bad_seen <= 1'b0;
               if (dec.start_l0) begin
                  state <= DATA;
                  acc   <= 16'd8;
               end else if (dec.start_l4) begin
                  state <= DATA;
                  acc   <= 16'd4;
               end
            end
            DATA: begin
               if (dec.start_l0) begin
                  acc      <= 16'd8;
                  bad_seen <= 1'b0;
               end else if (dec.term_vld) begin
                  bad_seen <= 1'b0;
                  if (dec.start_l4 && dec.term_lane < 3'd4) acc <= 16'd4;
                  else                                      state <= IDLE;
               end else if (dec.start_l4) begin
                  acc      <= 16'd4;
                  bad_seen <= 1'b0;
               end else begin
                  acc      <= sat_add16(acc, 16'd8);
                  bad_seen <= bad_seen | dec.err | dec.other_ctl;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign tick      = (tick_cnt == 32'(TICK_CYCLES - 1));
   assign good      = frame_done & ~frame_bad;
   assign pps_next  = sat_add32(pps_acc, {31'd0, good});
   assign byte_next = sat_add32(byte_acc, good ? {16'd0, frame_len} : 32'd0);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         tick_cnt      <= '0;
         pps_acc       <= '0;
         byte_acc      <= '0;
         rx_pps        <= '0;
         rx_throughput <= '0;
         rx_err_total  <= '0;
         period_tick   <= 1'b0;
      end else begin
         tick_cnt    <= tick ? 32'd0 : tick_cnt + 32'd1;
         period_tick <= tick;
         // A good frame closing on the tick lands in the outgoing snapshot.
         if (tick) begin
            rx_pps        <= pps_next;
            rx_throughput <= byte_next;
            pps_acc       <= '0;
            byte_acc      <= '0;
         end else begin
            pps_acc  <= pps_next;
            byte_acc <= byte_next;
         end
         if (frame_done && frame_bad) rx_err_total <= sat_add32(rx_err_total, 32'd1);
      end
   end
endmodule
